// File: rtl/eth_rx_pkg.sv
// Shared RX-path constants: preamble/SFD byte values and the calibration FSM states.
package eth_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_OBSERVE = 4'd3,
    ST_EVAL    = 4'd4,
    ST_FINAL   = 4'd5,
    ST_LOAD_F  = 4'd6,
    ST_DONE    = 4'd7,
    ST_FAIL    = 4'd8
  } cal_state_e;

endpackage

// File: rtl/rgmii_preamble_chk.sv
// Judges the preamble/SFD of each GMII frame whose dv rising edge falls while armed.
//  clk, rst_n      : clock, async active-low reset
//  arm             : observation window open; dropping it abandons any frame in progress
//  dv, rxd         : GMII receive valid/data
//  frame_good/bad  : 1-cycle verdict pulses, one cycle after byte 8 or the early dv fall
module rgmii_preamble_chk
  import eth_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       dv,
  input  logic [7:0] rxd,
  output logic       frame_good,
  output logic       frame_bad
);

  localparam int unsigned IDX_W = $clog2(PREAMBLE_LEN + 1);

  logic             dv_prev_q, dv_prev_d;
  logic             in_frame_q, in_frame_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;   // bytes already consumed in the current frame
  logic             good_q, good_d;
  logic             bad_q, bad_d;

  // dv_prev tracks dv even when disarmed, so a frame already running at arm time shows no edge
  always_comb begin
    dv_prev_d  = dv;
    in_frame_d = in_frame_q;
    err_d      = err_q;
    idx_d      = idx_q;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    if (!arm) begin
      in_frame_d = 1'b0;
      err_d      = 1'b0;
      idx_d      = '0;
    end else if (in_frame_q) begin
      if (!dv) begin
        bad_d      = 1'b1;
        in_frame_d = 1'b0;
      end else if (idx_q == IDX_W'(PREAMBLE_LEN)) begin
        good_d     = !err_q && (rxd == SFD_BYTE);
        bad_d      = err_q || (rxd != SFD_BYTE);
        in_frame_d = 1'b0;
      end else begin
        err_d = err_q || (rxd != PREAMBLE_BYTE);
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (dv && !dv_prev_q) begin
      in_frame_d = 1'b1;
      err_d      = (rxd != PREAMBLE_BYTE);
      idx_d      = IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_prev_q  <= 1'b0;
      in_frame_q <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      dv_prev_q  <= dv_prev_d;
      in_frame_q <= in_frame_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign frame_good = good_q;
  assign frame_bad  = bad_q;

endmodule

// File: rtl/rgmii_idelay_cal.sv
// RGMII RX IDELAY calibration: scans every tap, qualifies each by preamble/SFD checks,
// then loads the centre of the longest contiguous passing window (earliest wins ties).
//  gmii_rx_clk, rst_n     : clock, async active-low reset
//  cal_start              : start pulse, ignored while busy
//  gmii_rx_dv, gmii_rxd   : GMII receive stream
//  idelay_tap, idelay_ld  : tap value and 1-cycle load strobe to the IDELAY
//  cal_busy/done/fail     : scan status (done/fail sticky until next start)
//  win_start, win_len     : best window found by the last scan
module rgmii_idelay_cal
  import eth_rx_pkg::*;
#(
  parameter int unsigned TAP_W          = 5,
  parameter int unsigned NUM_TAPS       = 32,
  parameter int unsigned DEFAULT_TAP    = 0,
  parameter int unsigned SETTLE_CYC     = 16,
  parameter int unsigned FRAMES_PER_TAP = 4,
  parameter int unsigned TIMEOUT_CYC    = 1 << 20,
  parameter int unsigned MIN_WINDOW     = 3
) (
  input  logic             gmii_rx_clk,
  input  logic             rst_n,
  input  logic             cal_start,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic [TAP_W-1:0] idelay_tap,
  output logic             idelay_ld,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] win_start,
  output logic [TAP_W:0]   win_len
);

  localparam int unsigned LEN_W  = TAP_W + 1;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GOOD_W = $clog2(FRAMES_PER_TAP + 1);

  cal_state_e        state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              ld_q, ld_d;
  logic              init_q, init_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [TAP_W-1:0]  win_start_q, win_start_d;
  logic [LEN_W-1:0]  win_len_q, win_len_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic              bad_seen_q, bad_seen_d;
  logic [TAP_W-1:0]  run_start_q, run_start_d;
  logic [LEN_W-1:0]  run_len_q, run_len_d;
  logic [TAP_W-1:0]  best_start_q, best_start_d;
  logic [LEN_W-1:0]  best_len_q, best_len_d;

  logic              frame_good, frame_bad;
  logic [GOOD_W-1:0] good_nxt;
  logic              tap_pass;
  logic              best_ok;

  rgmii_preamble_chk u_chk (
    .clk        (gmii_rx_clk),
    .rst_n      (rst_n),
    .arm        (state_q == ST_OBSERVE),
    .dv         (gmii_rx_dv),
    .rxd        (gmii_rxd),
    .frame_good (frame_good),
    .frame_bad  (frame_bad)
  );

  // Scan sequencing, per-tap qualification and best-window tracking
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    init_d       = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_seen_d   = bad_seen_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    good_nxt     = good_cnt_q + GOOD_W'(frame_good);
    tap_pass     = (good_cnt_q == GOOD_W'(FRAMES_PER_TAP)) && !bad_seen_q;
    best_ok      = (best_len_q >= LEN_W'(MIN_WINDOW));

    unique case (state_q)
      ST_IDLE: begin
        if (cal_start) begin
          state_d      = ST_LOAD;
          tap_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          win_start_d  = '0;
          win_len_d    = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = '0;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d    = ST_OBSERVE;
          good_cnt_d = '0;
          bad_seen_d = 1'b0;
          tmo_cnt_d  = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_OBSERVE: begin
        good_cnt_d = good_nxt;
        tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
        if (frame_bad) begin
          bad_seen_d = 1'b1;
          state_d    = ST_EVAL;
        end else if ((good_nxt == GOOD_W'(FRAMES_PER_TAP)) ||
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1))) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Best-window compare uses the run length including this tap
        if (tap_pass) begin
          run_len_d   = run_len_q + LEN_W'(1);
          run_start_d = (run_len_q == '0) ? tap_q : run_start_q;
        end else begin
          run_len_d = '0;
        end
        if (run_len_d > best_len_q) begin
          best_start_d = run_start_d;
          best_len_d   = run_len_d;
        end
        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d = ST_FINAL;
        end else begin
          tap_d   = tap_q + TAP_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_FINAL: begin
        tap_d   = best_ok ? best_start_q + TAP_W'(best_len_q >> 1) : TAP_W'(DEFAULT_TAP);
        state_d = ST_LOAD_F;
      end
      ST_LOAD_F: begin
        busy_d      = 1'b0;
        win_start_d = best_start_q;
        win_len_d   = best_len_q;
        done_d      = best_ok;
        fail_d      = !best_ok;
        state_d     = best_ok ? ST_DONE : ST_FAIL;
      end
      ST_DONE, ST_FAIL: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase

    // Strobe coincides with the LOAD states; init_q adds the post-reset default reload
    ld_d = init_q || (state_d == ST_LOAD) || (state_d == ST_LOAD_F);
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tap_q        <= TAP_W'(DEFAULT_TAP);
      ld_q         <= 1'b0;
      init_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      win_start_q  <= '0;
      win_len_q    <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      good_cnt_q   <= '0;
      bad_seen_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      ld_q         <= ld_d;
      init_q       <= init_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_seen_q   <= bad_seen_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign idelay_tap = tap_q;
  assign idelay_ld  = ld_q;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;
  assign cal_fail   = fail_q;
  assign win_start  = win_start_q;
  assign win_len    = win_len_q;

endmodule

// File: tb/tb_rgmii_idelay_cal.sv
// Bench for rgmii_idelay_cal: per-tap traffic scenarios against a window-search model.
module tb_rgmii_idelay_cal;

  localparam int unsigned TAP_W       = 5;
  localparam int unsigned NUM_TAPS    = 32;
  localparam int unsigned DEFAULT_TAP = 7;
  localparam int unsigned SETTLE_CYC  = 16;
  localparam int unsigned FPT         = 4;
  localparam int unsigned TIMEOUT_CYC = 200;
  localparam int unsigned MIN_WINDOW  = 3;

  typedef enum int {SC_PASS, SC_BAD_SFD, SC_BAD_PRE, SC_SHORT, SC_NONE, SC_STRAD3, SC_STRAD4} sc_e;
  typedef enum int {FR_GOOD, FR_BAD_SFD, FR_BAD_PRE, FR_SHORT} fr_e;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cal_start;
  logic             dv;
  logic [7:0]       rxd;
  logic [TAP_W-1:0] idelay_tap;
  logic             idelay_ld;
  logic             cal_busy, cal_done, cal_fail;
  logic [TAP_W-1:0] win_start;
  logic [TAP_W:0]   win_len;

  rgmii_idelay_cal #(
    .TAP_W(TAP_W), .NUM_TAPS(NUM_TAPS), .DEFAULT_TAP(DEFAULT_TAP), .SETTLE_CYC(SETTLE_CYC),
    .FRAMES_PER_TAP(FPT), .TIMEOUT_CYC(TIMEOUT_CYC), .MIN_WINDOW(MIN_WINDOW)
  ) dut (
    .gmii_rx_clk(clk), .rst_n(rst_n), .cal_start(cal_start), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .idelay_tap(idelay_tap), .idelay_ld(idelay_ld), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_fail(cal_fail), .win_start(win_start), .win_len(win_len)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  ld_total = 0;
  int  ld_cyc_q[$];
  int  ld_tap_q[$];
  sc_e plan[NUM_TAPS];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every load strobe with its cycle and tap value
  always @(negedge clk) begin
    if (idelay_ld === 1'b1) begin
      ld_cyc_q.push_back(cyc);
      ld_tap_q.push_back(int'(idelay_tap));
      ld_total++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_frame(input fr_e kind, input int pay, input int ipg);
    logic [7:0] b;
    int nb;
    int badpos;
    nb     = (kind == FR_SHORT) ? 5 : 8 + pay;
    badpos = int'($urandom_range(2, 7));
    for (int i = 1; i <= nb; i++) begin
      if (i <= 7)       b = 8'h55;
      else if (i == 8)  b = 8'hD5;
      else              b = 8'($urandom);
      if (kind == FR_BAD_SFD && i == 8)      b = 8'hD5 ^ (8'h01 << 3'($urandom_range(0, 7)));
      if (kind == FR_BAD_PRE && i == badpos) b = 8'h55 ^ (8'h01 << 3'($urandom_range(0, 7)));
      dv  = 1'b1;
      rxd = b;
      @(negedge clk);
    end
    dv  = 1'b0;
    rxd = 8'($urandom);
    repeat (ipg) @(negedge clk);
  endtask

  // Traffic for one tap; lc is the cycle its load strobe was seen
  task automatic do_tap(input sc_e sc, input int lc);
    int ng;
    case (sc)
      SC_PASS: begin
        wait_until(lc + int'(SETTLE_CYC) + 2 + int'($urandom_range(0, 3)));
        for (int f = 0; f < int'(FPT); f++)
          send_frame(FR_GOOD, (f == int'(FPT) - 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 10)),
                     int'($urandom_range(1, 4)));
      end
      SC_BAD_SFD, SC_BAD_PRE, SC_SHORT: begin
        wait_until(lc + int'(SETTLE_CYC) + 2 + int'($urandom_range(0, 10)));
        ng = int'($urandom_range(0, 2));
        for (int f = 0; f < ng; f++) send_frame(FR_GOOD, int'($urandom_range(0, 8)), int'($urandom_range(1, 4)));
        send_frame((sc == SC_BAD_SFD) ? FR_BAD_SFD : (sc == SC_BAD_PRE) ? FR_BAD_PRE : FR_SHORT,
                   int'($urandom_range(0, 3)), 1);
      end
      SC_STRAD3, SC_STRAD4: begin
        // Frame already running when observation opens must not count
        wait_until(lc + int'(SETTLE_CYC) - 1);
        send_frame(FR_GOOD, 12, int'($urandom_range(2, 4)));
        for (int f = 0; f < ((sc == SC_STRAD4) ? int'(FPT) : int'(FPT) - 1); f++)
          send_frame(FR_GOOD, int'($urandom_range(0, 6)), int'($urandom_range(1, 4)));
      end
      default: ;
    endcase
  endtask

  // Reference: longest run of passing taps, earliest on ties, centre or default
  task automatic model_scan(output int bs, output int bl, output int tap, output int ok);
    bit p[NUM_TAPS];
    int i, j;
    for (int k = 0; k < int'(NUM_TAPS); k++) p[k] = (plan[k] == SC_PASS) || (plan[k] == SC_STRAD4);
    bs = 0; bl = 0; i = 0;
    while (i < int'(NUM_TAPS)) begin
      if (p[i]) begin
        j = i;
        while (j < int'(NUM_TAPS) && p[j]) j++;
        if (j - i > bl) begin bl = j - i; bs = i; end
        i = j;
      end else begin
        i++;
      end
    end
    ok  = (bl >= int'(MIN_WINDOW)) ? 1 : 0;
    tap = ok ? bs + bl / 2 : int'(DEFAULT_TAP);
  endtask

  task automatic pulse_start();
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_ld(input int k, output bit ok);
    int n;
    n = 0;
    while (ld_total <= k && n < 3000) begin @(negedge clk); n++; end
    ok = (ld_total > k);
  endtask

  task automatic run_scan(input string name, input int extra_start_tap, input int rst_tap);
    int base, bs, bl, tap, ok, n;
    bit got;
    base = ld_total;
    pulse_start();
    chk({name, "_busy_set"}, longint'(cal_busy), 1);
    chk({name, "_done_clr"}, longint'(cal_done), 0);
    chk({name, "_fail_clr"}, longint'(cal_fail), 0);
    for (int t = 0; t < int'(NUM_TAPS); t++) begin
      wait_ld(base + t, got);
      if (!got) begin chk({name, "_ld_wait"}, 0, 1); return; end
      chk({name, "_scan_tap"}, longint'(ld_tap_q[base + t]), longint'(t));
      if (t == rst_tap) begin
        @(negedge clk);
        rst_n = 1'b0;
        dv    = 1'b0;
        #1;
        chk("rst_mid_tap", longint'(idelay_tap), longint'(DEFAULT_TAP));
        chk("rst_mid_ld", longint'(idelay_ld), 0);
        chk("rst_mid_busy", longint'(cal_busy), 0);
        chk("rst_mid_done", longint'(cal_done), 0);
        chk("rst_mid_win", longint'({win_start, win_len}), 0);
        repeat (3) @(negedge clk);
        base  = ld_total;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_reload_cnt", longint'(ld_total - base), 1);
        chk("rst_mid_reload_tap", longint'(ld_tap_q[ld_total - 1]), longint'(DEFAULT_TAP));
        chk("rst_mid_idle", longint'(cal_busy), 0);
        return;
      end
      if (t == extra_start_tap) pulse_start();
      do_tap(plan[t], ld_cyc_q[base + t]);
    end
    n = 0;
    while (cal_busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    chk({name, "_busy_drop"}, longint'(cal_busy), 0);
    model_scan(bs, bl, tap, ok);
    chk({name, "_ld_count"}, longint'(ld_total - base), longint'(NUM_TAPS + 1));
    chk({name, "_final_ld_tap"}, longint'(ld_tap_q[ld_total - 1]), longint'(tap));
    chk({name, "_tap"}, longint'(idelay_tap), longint'(tap));
    chk({name, "_win_start"}, longint'(win_start), longint'(bs));
    chk({name, "_win_len"}, longint'(win_len), longint'(bl));
    chk({name, "_done"}, longint'(cal_done), longint'(ok));
    chk({name, "_fail"}, longint'(cal_fail), longint'(1 - ok));
    repeat (3) @(negedge clk);
  endtask

  task automatic plan_window(input int a0, input int a1, input int b0, input int b1);
    for (int t = 0; t < int'(NUM_TAPS); t++)
      plan[t] = ((t >= a0 && t <= a1) || (t >= b0 && t <= b1)) ? SC_PASS : SC_BAD_SFD;
  endtask

  task automatic plan_random();
    int r;
    for (int t = 0; t < int'(NUM_TAPS); t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      plan[t] = SC_PASS;
      else if (r < 65) plan[t] = SC_STRAD4;
      else if (r < 75) plan[t] = SC_BAD_SFD;
      else if (r < 83) plan[t] = SC_BAD_PRE;
      else if (r < 91) plan[t] = SC_SHORT;
      else if (r < 96) plan[t] = SC_STRAD3;
      else             plan[t] = SC_NONE;
    end
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    cal_start = 1'b0;
    dv        = 1'b0;
    rxd       = 8'h00;
    repeat (4) @(negedge clk);
    chk("por_tap", longint'(idelay_tap), longint'(DEFAULT_TAP));
    chk("por_ld", longint'(idelay_ld), 0);
    chk("por_status", longint'({cal_busy, cal_done, cal_fail}), 0);
    chk("por_win", longint'({win_start, win_len}), 0);
    base  = ld_total;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("por_reload_cnt", longint'(ld_total - base), 1);
    chk("por_reload_tap", longint'(ld_tap_q[ld_total - 1]), longint'(DEFAULT_TAP));

    for (int t = 0; t < int'(NUM_TAPS); t++) plan[t] = SC_PASS;
    run_scan("all_pass", -1, -1);

    plan_window(10, 17, 99, 99);
    run_scan("win_10_17", -1, -1);

    plan_window(3, 5, 20, 27);
    run_scan("win_longer_later", -1, -1);

    plan_window(2, 5, 9, 12);
    run_scan("win_tie", -1, -1);

    for (int t = 0; t < int'(NUM_TAPS); t++)
      plan[t] = (t % 3 == 0) ? SC_BAD_SFD : (t % 3 == 1) ? SC_SHORT : SC_BAD_PRE;
    run_scan("none_pass", -1, -1);

    plan_window(5, 6, 99, 99);
    run_scan("win_too_short", -1, -1);

    for (int t = 0; t < int'(NUM_TAPS); t++) plan[t] = SC_PASS;
    plan[3]  = SC_NONE;
    plan[10] = SC_SHORT;
    plan[20] = SC_STRAD3;
    plan[25] = SC_STRAD4;
    run_scan("timeout_mix", -1, -1);

    for (int t = 0; t < int'(NUM_TAPS); t++) plan[t] = SC_PASS;
    run_scan("start_while_busy", 5, -1);
    run_scan("reset_mid", -1, 12);
    run_scan("after_reset", -1, -1);

    for (int s = 0; s < 3; s++) begin
      plan_random();
      run_scan($sformatf("rand%0d", s), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
